pt_checker: RTL and testbench

- Consumer stage directly downstream of the ARC4 decrypt core inside the task5 key-cracker.
- After each candidate key has been decrypted, it scans the length-prefixed plaintext memory and reports whether every message byte is printable ASCII.
- The crack controller uses the pass/fail result to either stop and display the key or advance to the next key.
- Reads one byte per cycle through a fixed-latency synchronous RAM port, with pipelined address issue.

---
 rtl/pt_checker_pkg.sv | 22 ++
 rtl/pt_checker.sv | 143 ++++++++++++++
 tb/tb_pt_checker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pt_checker_pkg.sv
// Shared types, constants and helpers for the plaintext printability checker.
package pt_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LEN,
        WAIT_LEN,
        SCAN,
        DONE
    } pt_state_t;

    localparam logic [7:0] PT_LEN_ADDR  = 8'h00;
    localparam logic [7:0] PRINT_LO_DEF = 8'h20;
    localparam logic [7:0] PRINT_HI_DEF = 8'h7E;

    function automatic logic is_printable(input logic [7:0] data,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (data >= lo) && (data <= hi);
    endfunction

endpackage

// File: rtl/pt_checker.sv
// Scans length-prefixed plaintext memory and reports whether every byte is printable.
// Optional build macro PT_EARLY_ABORT_EN: finish on the first non-printable byte.
module pt_checker
    import pt_checker_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [7:0]  PRINT_LO    = PRINT_LO_DEF,
    parameter logic [7:0]  PRINT_HI    = PRINT_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    input  logic [7:0] rddata,
    output logic       valid,
    output logic       printable,
    output logic [7:0] fail_idx
);

`ifdef PT_EARLY_ABORT_EN
    localparam bit EarlyAbort = 1'b1;
`else
    localparam bit EarlyAbort = 1'b0;
`endif

    pt_state_t  state_q;
    logic [8:0] addr_q;
    logic       new_q;
    logic [7:0] len_q;
    logic       rdy_q;
    logic       valid_q;
    logic       printable_q;
    logic [7:0] fail_idx_q;

    // In-flight reads: entry i holds the read issued i+1 cycles ago.
    logic [MEM_LATENCY-1:0]      pipe_vld_q;
    logic [MEM_LATENCY-1:0][8:0] pipe_idx_q;

    logic       pipe_out_vld;
    logic [8:0] pipe_out_idx;
    logic       len_hit;
    logic       byte_hit;
    logic       byte_bad;
    logic       last_hit;
    logic       len_known;
    logic [8:0] len_eff;
    logic       accept;

    always_comb begin
        pipe_out_vld = pipe_vld_q[MEM_LATENCY-1];
        pipe_out_idx = pipe_idx_q[MEM_LATENCY-1];
        len_hit      = (state_q == WAIT_LEN) && pipe_out_vld
                       && (pipe_out_idx == {1'b0, PT_LEN_ADDR});
        byte_hit     = (state_q == SCAN) && pipe_out_vld
                       && (pipe_out_idx != 9'd0) && (pipe_out_idx <= {1'b0, len_q});
        byte_bad     = byte_hit && !is_printable(rddata, PRINT_LO, PRINT_HI);
        last_hit     = byte_hit && (pipe_out_idx == {1'b0, len_q});
        len_known    = len_hit || (state_q == SCAN);
        len_eff      = len_hit ? {1'b0, rddata} : {1'b0, len_q};
        accept       = rdy_q && en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 9'd0;
            new_q       <= 1'b0;
            len_q       <= 8'd0;
            rdy_q       <= 1'b1;
            valid_q     <= 1'b0;
            printable_q <= 1'b0;
            fail_idx_q  <= 8'd0;
            pipe_vld_q  <= '0;
            pipe_idx_q  <= '0;
        end else begin
            valid_q       <= 1'b0;
            new_q         <= 1'b0;
            pipe_vld_q[0] <= (state_q == RD_LEN) || new_q;
            pipe_idx_q[0] <= addr_q;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end

            case (state_q)
                IDLE, DONE: begin
                    addr_q <= {1'b0, PT_LEN_ADDR};
                    if (accept) begin
                        state_q     <= RD_LEN;
                        rdy_q       <= 1'b0;
                        printable_q <= 1'b1;
                        fail_idx_q  <= 8'd0;
                    end else begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                RD_LEN: begin
                    addr_q  <= 9'd1;
                    new_q   <= 1'b1;
                    state_q <= WAIT_LEN;
                end
                WAIT_LEN, SCAN: begin
                    if (len_hit) begin
                        len_q <= rddata;
                    end
                    // Addresses run ahead of the length read; clamp once L is known.
                    if (len_known && (addr_q >= len_eff)) begin
                        addr_q <= len_eff;
                    end else begin
                        addr_q <= addr_q + 9'd1;
                        new_q  <= 1'b1;
                    end
                    if (byte_bad && printable_q) begin
                        printable_q <= 1'b0;
                        fail_idx_q  <= pipe_out_idx[7:0];
                    end
                    if ((len_hit && (rddata == 8'd0)) || last_hit || (EarlyAbort && byte_bad)) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        rdy_q      <= 1'b1;
                        new_q      <= 1'b0;
                        pipe_vld_q <= '0;
                    end else if (len_hit) begin
                        state_q <= SCAN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign rdy       = rdy_q;
    assign addr      = addr_q[7:0];
    assign valid     = valid_q;
    assign printable = printable_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_pt_checker.sv
// Directed self-checking bench for pt_checker with a latency-1 synchronous RAM model.
module tb_pt_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] rddata;
    logic       valid;
    logic       printable;
    logic [7:0] fail_idx;

    logic [7:0] mem [256];
    logic [7:0] addr_log [300];
    int         errors;
    int         checks;
    int         n;

    pt_checker #(
        .MEM_LATENCY(1),
        .PRINT_LO   (8'h20),
        .PRINT_HI   (8'h7E)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rdy      (rdy),
        .addr     (addr),
        .rddata   (rddata),
        .valid    (valid),
        .printable(printable),
        .fail_idx (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rddata <= mem[addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse en for one edge, then count cycles until valid (cycle 1 follows the accept edge).
    task automatic run(input string tag, input int exp_cyc, input logic exp_pr,
                       input logic [7:0] exp_fi);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        n = 1;
        while (!valid && n < 290) begin
            addr_log[n] = addr;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_cycle"}, n, exp_cyc);
        chk({tag, "_printable"}, printable, exp_pr);
        chk({tag, "_fail_idx"}, fail_idx, exp_fi);
        chk({tag, "_rdy"}, rdy, 1'b1);
    endtask

    initial begin
        int vcount;
        logic wrapped;
        errors = 0;
        checks = 0;
        en     = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;
        chk("reset_rdy", rdy, 1'b1);
        chk("reset_valid", valid, 1'b0);
        chk("reset_addr", addr, 8'h00);
        chk("reset_printable", printable, 1'b0);
        chk("reset_fail_idx", fail_idx, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // "Hello"
        mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h65; mem[3] = 8'h6C;
        mem[4] = 8'h6C; mem[5] = 8'h6F;
        run("hello", 8, 1'b1, 8'd0);
        for (int i = 1; i <= 6; i++) chk("hello_addr_seq", addr_log[i], i - 1);

        // Control character at index 3
        mem[0] = 8'd4; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h07; mem[4] = 8'h43;
`ifdef PT_EARLY_ABORT_EN
        run("bell", 6, 1'b0, 8'd3);
`else
        run("bell", 7, 1'b0, 8'd3);
`endif

        // Boundary bytes: 20 and 7E pass, 1F and 7F fail, lowest index recorded
        mem[0] = 8'd4; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h1F; mem[4] = 8'h7F;
`ifdef PT_EARLY_ABORT_EN
        run("bound_fail", 6, 1'b0, 8'd3);
`else
        run("bound_fail", 7, 1'b0, 8'd3);
`endif
        mem[0] = 8'd2;
        run("bound_pass", 5, 1'b1, 8'd0);

        mem[0] = 8'd0;
        run("len0", 3, 1'b1, 8'd0);

        // Maximum length
        mem[0] = 8'd255;
        for (int i = 1; i < 256; i++) mem[i] = 8'h41;
        run("len255", 258, 1'b1, 8'd0);
        chk("len255_addr_last", addr_log[256], 8'd255);
        chk("len255_addr_hold", addr_log[257], 8'd255);
        wrapped = 1'b0;
        for (int i = 2; i <= 257; i++) if (addr_log[i] == 8'd0) wrapped = 1'b1;
        chk("len255_no_wrap", wrapped, 1'b0);

        // Reset in cycle 4 of an L=10 scan
        mem[0] = 8'd10;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", rdy, 1'b1);
        chk("abort_valid", valid, 1'b0);
        chk("abort_addr", addr, 8'h00);
        chk("abort_printable", printable, 1'b0);
        chk("abort_fail_idx", fail_idx, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        chk("abort_no_valid", vcount, 0);
        run("restart", 13, 1'b1, 8'd0);

        // en held high: second accept on the valid cycle
        mem[0] = 8'd3; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        while (!valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_first_cycle", n, 6);
        chk("b2b_first_rdy", rdy, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_reaccept_rdy", rdy, 1'b0);
        en = 1'b0;
        n = 1;
        while (!valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_second_cycle", n, 6);
        vcount = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        chk("b2b_no_third", vcount, 0);

        // en pulsed mid-scan is ignored
        mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h65; mem[3] = 8'h6C;
        mem[4] = 8'h6C; mem[5] = 8'h6F;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        vcount = 0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (n == 3) en = 1'b1;
            if (n == 4) en = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (valid) begin
                vcount++;
                chk("midscan_valid_cycle", n, 8);
            end
        end
        chk("midscan_one_valid", vcount, 1);
        chk("midscan_printable", printable, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
